// File: rtl/remote_comm.sv
// Host-side command sender: serializes a 16-bit command as two 8N1 frames
// (high byte first) and independently receives a one-byte response.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam logic [11:0] BAUD_TC = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_TC = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_st_t;

  tx_st_t      tx_st_q, tx_st_d;
  logic [7:0]  hold_lo_q, hold_lo_d;
  logic [9:0]  shft_q, shft_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic        snt_q, snt_d;
  logic        tx_acc;

  rx_st_t      rx_st_q, rx_st_d;
  logic        rx_meta_q, rx_s_q;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  resp_q, resp_d;
  logic        rdy_q, rdy_d;
  logic        rdy_set, rdy_clr;

  // Only the low byte must outlive the accept edge; the high byte goes
  // straight into the shifter.
  always_comb begin
    tx_st_d   = tx_st_q;
    hold_lo_d = hold_lo_q;
    shft_d    = shft_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    snt_d     = 1'b0;
    tx_acc    = 1'b0;
    case (tx_st_q)
      TX_IDLE: begin
        if (snd_cmd) begin
          tx_acc    = 1'b1;
          hold_lo_d = cmd[7:0];
          shft_d    = {1'b1, cmd[15:8], 1'b0};
          baud_d    = '0;
          bit_d     = '0;
          tx_st_d   = TX_HIGH;
        end
      end
      default: begin
        if (baud_q == BAUD_TC) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (tx_st_q == TX_HIGH) begin
              shft_d  = {1'b1, hold_lo_q, 1'b0};
              tx_st_d = TX_LOW;
            end else begin
              shft_d  = '1;
              snt_d   = 1'b1;
              tx_st_d = TX_IDLE;
            end
          end else begin
            bit_d  = bit_q + 4'd1;
            shft_d = {1'b1, shft_q[9:1]};
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
    endcase
  end

  // Stop-bit framing error parks DATA at bit 9 until the line returns high.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    resp_d   = resp_q;
    rdy_set  = 1'b0;
    rdy_clr  = clr_resp_rdy | tx_acc;
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
          rdy_clr  = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_TC) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_bit_q == 4'd9) begin
          if (rx_s_q) rx_st_d = RX_IDLE;
        end else if (rx_cnt_q == BAUD_TC) begin
          rx_cnt_d = '0;
          if (rx_bit_q == 4'd8) begin
            if (rx_s_q) begin
              resp_d  = rx_sh_q;
              rdy_set = 1'b1;
              rx_st_d = RX_IDLE;
            end else begin
              rx_bit_d = 4'd9;
            end
          end else begin
            rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
    rdy_d = rdy_set ? 1'b1 : (rdy_clr ? 1'b0 : rdy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= TX_IDLE;
      hold_lo_q <= '0;
      shft_q    <= '1;
      baud_q    <= '0;
      bit_q     <= '0;
      snt_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      resp_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      hold_lo_q <= hold_lo_d;
      shft_q    <= shft_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      snt_q     <= snt_d;
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      resp_q    <= resp_d;
      rdy_q     <= rdy_d;
    end
  end

  assign TX       = shft_q[0];
  assign cmd_snt  = snt_q;
  assign resp     = resp_q;
  assign resp_rdy = rdy_q;

endmodule
